counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 171 +++++++++++++++++
 tb/tb_counter_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Programmable up/down pass counter with repeat control, pause, abort and
// registered state, wrap and done indications.
module counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] repeat_n,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic [WIDTH-1:0] pass_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] pass_q, pass_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] rep_q, rep_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             terminal_s;
    logic             final_s;
    logic [WIDTH-1:0] pass_inc_s;

    // First value of a pass: bottom of the range counting up, top counting down.
    function automatic logic [WIDTH-1:0] start_val(input logic d, input logic [WIDTH-1:0] lim);
        logic [WIDTH-1:0] v;
        if (d) begin
            v = lim;
        end else begin
            v = {WIDTH{1'b0}};
        end
        return v;
    endfunction

    // Last value of a pass, opposite end of the range from start_val.
    function automatic logic [WIDTH-1:0] term_val(input logic d, input logic [WIDTH-1:0] lim);
        logic [WIDTH-1:0] v;
        if (d) begin
            v = {WIDTH{1'b0}};
        end else begin
            v = lim;
        end
        return v;
    endfunction

    // Pass bookkeeping shared by the next-state logic.
    always_comb begin
        terminal_s = (count_q == term_val(dir_q, limit_q));
        pass_inc_s = pass_q + WIDTH'(1);
        final_s    = (rep_q != {WIDTH{1'b0}}) && (pass_inc_s == rep_q);
    end

    // Next-state and next-output logic; stop overrides everything else.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pass_d  = pass_q;
        limit_d = limit_q;
        rep_d   = rep_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            count_d = {WIDTH{1'b0}};
            pass_d  = {WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        limit_d = limit;
                        dir_d   = dir;
                        rep_d   = repeat_n;
                        count_d = start_val(dir, limit);
                        pass_d  = {WIDTH{1'b0}};
                        state_d = ST_RUN;
                    end else if (state_q == ST_IDLE) begin
                        count_d = {WIDTH{1'b0}};
                    end else begin
                        count_d = count_q;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (terminal_s) begin
                        pass_d = pass_inc_s;
                        wrap_d = 1'b1;
                        if (final_s) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            count_d = start_val(dir_q, limit_q);
                        end
                    end else if (dir_q) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                ST_PAUSE: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = {WIDTH{1'b0}};
                    pass_d  = {WIDTH{1'b0}};
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    // State, counters, latched configuration and output flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= {WIDTH{1'b0}};
            pass_q  <= {WIDTH{1'b0}};
            limit_q <= {WIDTH{1'b0}};
            rep_q   <= {WIDTH{1'b0}};
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pass_q  <= pass_d;
            limit_q <= limit_d;
            rep_q   <= rep_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign count    = count_q;
    assign state    = state_q;
    assign busy     = busy_q;
    assign wrap     = wrap_q;
    assign done     = done_q;
    assign pass_cnt = pass_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: vector table, directed corner
// sequences and randomized traffic against a pass/position reference model.
module tb_counter_sequencer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0, stop = 1'b0, pause = 1'b0, dir = 1'b0;
    logic [W-1:0] limit = 4'd0, repeat_n = 4'd0;
    logic [W-1:0] count, pass_cnt;
    logic [1:0]   state;
    logic         busy, wrap, done;

    int total = 0;
    int bad   = 0;

    counter_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .dir(dir), .limit(limit), .repeat_n(repeat_n), .count(count),
        .state(state), .busy(busy), .wrap(wrap), .done(done), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, sp, pa, d;
        logic [3:0] lim, rep;
        logic [3:0] e_cnt;
        logic [1:0] e_state;
        logic       e_wrap, e_done;
        logic [3:0] e_pass;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, sp, pa, d, input logic [3:0] lim, rep,
                                input logic [3:0] c, input logic [1:0] s,
                                input logic w, dn, input logic [3:0] p);
        vec_t v;
        v.st = st; v.sp = sp; v.pa = pa; v.d = d; v.lim = lim; v.rep = rep;
        v.e_cnt = c; v.e_state = s; v.e_wrap = w; v.e_done = dn; v.e_pass = p;
        return v;
    endfunction

    // Packed observation: {state, busy, wrap, done, count, pass_cnt}
    function automatic logic [12:0] pack(input logic [1:0] s, input logic w, dn,
                                         input logic [3:0] c, p);
        logic b;
        b = (s == 2'b01) || (s == 2'b10);
        return {s, b, w, dn, c, p};
    endfunction

    function automatic logic [12:0] obs();
        return {state, busy, wrap, done, count, pass_cnt};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, sp, pa, d, input logic [3:0] lim, rep);
        start = st; stop = sp; pause = pa; dir = d; limit = lim; repeat_n = rep;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: mode plus position within the current pass.
    int         m_mode, m_pos;
    logic [3:0] m_pass, m_lim, m_rep;
    logic       m_dir, m_wrap, m_done;

    task automatic m_reset();
        m_mode = 0; m_pos = 0; m_pass = 4'd0; m_lim = 4'd0; m_rep = 4'd0;
        m_dir = 1'b0; m_wrap = 1'b0; m_done = 1'b0;
    endtask

    task automatic m_step();
        m_wrap = 1'b0;
        m_done = 1'b0;
        if (stop) begin
            m_mode = 0; m_pos = 0; m_pass = 4'd0;
        end else begin
            case (m_mode)
                0, 3: if (start) begin
                    m_lim = limit; m_dir = dir; m_rep = repeat_n;
                    m_pos = 0; m_pass = 4'd0; m_mode = 1;
                end
                1: if (pause) m_mode = 2;
                   else if (m_pos == int'(m_lim)) begin
                       m_pass = m_pass + 4'd1;
                       m_wrap = 1'b1;
                       if (m_rep != 4'd0 && m_pass == m_rep) begin
                           m_mode = 3; m_done = 1'b1;
                       end else m_pos = 0;
                   end else m_pos++;
                2: if (!pause) m_mode = 1;
                default: ;
            endcase
        end
    endtask

    function automatic logic [12:0] m_obs();
        logic [3:0] c;
        if (m_mode == 0) c = 4'd0;
        else if (m_dir) c = m_lim - 4'(m_pos);
        else c = 4'(m_pos);
        return pack(2'(m_mode), m_wrap, m_done, c, m_pass);
    endfunction

    initial begin
        // Reset state before any clock edge, then idle with no start
        #2;
        chk("reset_async", 32'(obs()), 32'(pack(2'b00, 1'b0, 1'b0, 4'd0, 4'd0)));
        #5 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_hold", 32'(obs()), 32'(pack(2'b00, 1'b0, 1'b0, 4'd0, 4'd0)));
        end

        // Vector table: up/down runs, ignored config changes, limit=0, stop wins
        tbl.push_back(mk(1,0,0,0, 4'd3,4'd2, 4'd0,2'b01,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0, 4'd3,4'd2, 4'd1,2'b01,0,0,4'd0));
        tbl.push_back(mk(0,0,0,1, 4'd9,4'd0, 4'd2,2'b01,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0, 4'd3,4'd2, 4'd3,2'b01,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0, 4'd3,4'd2, 4'd0,2'b01,1,0,4'd1));
        tbl.push_back(mk(0,0,0,0, 4'd3,4'd2, 4'd1,2'b01,0,0,4'd1));
        tbl.push_back(mk(0,0,0,0, 4'd3,4'd2, 4'd2,2'b01,0,0,4'd1));
        tbl.push_back(mk(0,0,0,0, 4'd3,4'd2, 4'd3,2'b01,0,0,4'd1));
        tbl.push_back(mk(0,0,0,0, 4'd3,4'd2, 4'd3,2'b11,1,1,4'd2));
        tbl.push_back(mk(0,0,0,0, 4'd3,4'd2, 4'd3,2'b11,0,0,4'd2));
        tbl.push_back(mk(1,0,0,1, 4'd5,4'd1, 4'd5,2'b01,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0, 4'd9,4'd0, 4'd4,2'b01,0,0,4'd0));
        tbl.push_back(mk(0,0,0,1, 4'd5,4'd1, 4'd3,2'b01,0,0,4'd0));
        tbl.push_back(mk(0,0,0,1, 4'd5,4'd1, 4'd2,2'b01,0,0,4'd0));
        tbl.push_back(mk(0,0,0,1, 4'd5,4'd1, 4'd1,2'b01,0,0,4'd0));
        tbl.push_back(mk(0,0,0,1, 4'd5,4'd1, 4'd0,2'b01,0,0,4'd0));
        tbl.push_back(mk(0,0,0,1, 4'd5,4'd1, 4'd0,2'b11,1,1,4'd1));
        tbl.push_back(mk(0,0,0,1, 4'd5,4'd1, 4'd0,2'b11,0,0,4'd1));
        tbl.push_back(mk(0,1,0,0, 4'd5,4'd1, 4'd0,2'b00,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0, 4'd5,4'd1, 4'd0,2'b00,0,0,4'd0));
        tbl.push_back(mk(1,0,0,0, 4'd0,4'd0, 4'd0,2'b01,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0, 4'd0,4'd0, 4'd0,2'b01,1,0,4'd1));
        tbl.push_back(mk(0,0,0,0, 4'd0,4'd0, 4'd0,2'b01,1,0,4'd2));
        tbl.push_back(mk(0,1,0,0, 4'd0,4'd0, 4'd0,2'b00,0,0,4'd0));
        tbl.push_back(mk(1,0,0,0, 4'd0,4'd1, 4'd0,2'b01,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0, 4'd0,4'd1, 4'd0,2'b11,1,1,4'd1));
        tbl.push_back(mk(1,1,0,0, 4'd2,4'd1, 4'd0,2'b00,0,0,4'd0));
        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].d, tbl[i].lim, tbl[i].rep);
            tick();
            chk($sformatf("vec%0d", i), 32'(obs()),
                32'(pack(tbl[i].e_state, tbl[i].e_wrap, tbl[i].e_done, tbl[i].e_cnt, tbl[i].e_pass)));
        end

        // Pause at count=4 for three cycles, then resume
        drive(1,0,0,0, 4'd7,4'd0); tick();
        drive(0,0,0,0, 4'd7,4'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("pause_pre", 32'(count), 32'd4);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pause_hold", 32'(obs()), 32'(pack(2'b10, 1'b0, 1'b0, 4'd4, 4'd0)));
        end
        pause = 1'b0;
        tick();
        chk("pause_exit", 32'(obs()), 32'(pack(2'b01, 1'b0, 1'b0, 4'd4, 4'd0)));
        for (int i = 5; i <= 7; i++) begin
            tick();
            chk("pause_resume", 32'(count), 32'(i));
        end
        tick();
        chk("pause_wrap", 32'(obs()), 32'(pack(2'b01, 1'b1, 1'b0, 4'd0, 4'd1)));

        // start ignored in RUN; start+stop aborts to IDLE
        drive(0,1,0,0, 4'd7,4'd0); tick();
        drive(1,0,0,0, 4'd7,4'd0); tick();
        drive(0,0,0,0, 4'd7,4'd0); tick(); tick();
        chk("run_at2", 32'(count), 32'd2);
        start = 1'b1; tick();
        chk("start_ignored", 32'(obs()), 32'(pack(2'b01, 1'b0, 1'b0, 4'd3, 4'd0)));
        stop = 1'b1; tick();
        chk("start_stop", 32'(obs()), 32'(pack(2'b00, 1'b0, 1'b0, 4'd0, 4'd0)));

        // Asynchronous reset mid-run at count=6
        drive(1,0,0,0, 4'd7,4'd0); tick();
        drive(0,0,0,0, 4'd7,4'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("pre_reset", 32'(count), 32'd6);
        #3 reset = 1'b0;
        #1 chk("mid_reset", 32'(obs()), 32'(pack(2'b00, 1'b0, 1'b0, 4'd0, 4'd0)));
        tick();
        reset = 1'b1;
        tick();
        chk("post_reset_idle", 32'(obs()), 32'(pack(2'b00, 1'b0, 1'b0, 4'd0, 4'd0)));
        drive(1,0,0,0, 4'd2,4'd0); tick();
        chk("restart0", 32'(count), 32'd0);
        drive(0,0,0,0, 4'd2,4'd0);
        tick(); chk("restart1", 32'(count), 32'd1);
        tick(); chk("restart2", 32'(count), 32'd2);
        tick(); chk("restart_wrap", 32'(obs()), 32'(pack(2'b01, 1'b1, 1'b0, 4'd0, 4'd1)));

        // Randomized traffic against the reference model
        #2 reset = 1'b0;
        m_reset();
        #1 chk("rand_reset", 32'(obs()), 32'(m_obs()));
        reset = 1'b1;
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 6)), 4'($urandom_range(0, 3)));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                m_reset();
                #2 chk("rand_async_reset", 32'(obs()), 32'(m_obs()));
                reset = 1'b1;
            end
            m_step();
            tick();
            chk($sformatf("rand%0d", i), 32'(obs()), 32'(m_obs()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
